// File: rtl/bp_pkg.sv
// Shared types and constants for the branch predictor.
//   bp_ctr_t     : 2-bit saturating counter state
//   BP_STRONG_NT : 00, BP_WEAK_NT : 01, BP_WEAK_T : 10, BP_STRONG_T : 11
// The taken prediction is the counter's MSB.
package bp_pkg;

    typedef logic [1:0] bp_ctr_t;

    localparam bp_ctr_t BP_STRONG_NT = 2'b00;
    localparam bp_ctr_t BP_WEAK_NT   = 2'b01;
    localparam bp_ctr_t BP_WEAK_T    = 2'b10;
    localparam bp_ctr_t BP_STRONG_T  = 2'b11;

endpackage

// File: rtl/sat_ctr2_update.sv
// Next-state function of a 2-bit saturating branch counter.
//   ctr_i   : current counter state
//   taken_i : resolved outcome, 1 = taken
//   ctr_o   : next state (taken -> +1 saturating at 11, else -1 saturating at 00)
module sat_ctr2_update
    import bp_pkg::*;
(
    input  bp_ctr_t ctr_i,
    input  logic    taken_i,
    output bp_ctr_t ctr_o
);

    always_comb begin
        // NOTE: default assignment first, so no path through the block leaves
        // ctr_o unassigned and no latch is inferred.
        ctr_o = ctr_i;
        if (taken_i) begin
            if (ctr_i != BP_STRONG_T) ctr_o = ctr_i + 2'd1;
        end else begin
            if (ctr_i != BP_STRONG_NT) ctr_o = ctr_i - 2'd1;
        end
    end

endmodule

// File: rtl/branch_history_table.sv
// Table of 2-bit saturating branch counters for the fetch stage.
//   clk_i, rst_n_i    : clock, asynchronous active-low reset
//   desactivar_bp_i   : predictor disabled; table cleared every edge
//   lookup_valid_i/lookup_pc_i : prediction request from IF
//   pred_valid_o/pred_taken_o/pred_state_o : registered prediction, 1-cycle latency
//   upd_valid_i/upd_pc_i/upd_taken_i       : resolved branch update from EX/MEM
// Both ports index with pc[IDX_LSB +: IDX_W]; different PCs may alias.
module branch_history_table
    import bp_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int PC_W    = 32,
    parameter int IDX_LSB = 2
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            desactivar_bp_i,
    input  logic            lookup_valid_i,
    input  logic [PC_W-1:0] lookup_pc_i,
    output logic            pred_valid_o,
    output logic            pred_taken_o,
    output logic [1:0]      pred_state_o,
    input  logic            upd_valid_i,
    input  logic [PC_W-1:0] upd_pc_i,
    input  logic            upd_taken_i
);

    localparam int IDX_W = $clog2(ENTRIES);

    bp_ctr_t          ctr_q [ENTRIES];
    logic [IDX_W-1:0] lk_idx;
    logic [IDX_W-1:0] upd_idx;
    bp_ctr_t          upd_cur;
    bp_ctr_t          upd_nxt;
    bp_ctr_t          lk_state;

    assign lk_idx  = lookup_pc_i[IDX_LSB +: IDX_W];
    assign upd_idx = upd_pc_i[IDX_LSB +: IDX_W];
    assign upd_cur = ctr_q[upd_idx];

    // PC bits outside the index field carry no information for this table.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{lookup_pc_i, upd_pc_i};

    sat_ctr2_update u_upd (
        .ctr_i   (upd_cur),
        .taken_i (upd_taken_i),
        .ctr_o   (upd_nxt)
    );

    // Lookup result: forced to 00 while disabled, otherwise write-first
    // forwarding of a same-cycle update to the same entry.
    always_comb begin
        lk_state = ctr_q[lk_idx];
        if (desactivar_bp_i) begin
            lk_state = BP_STRONG_NT;
        end else if (upd_valid_i && (upd_idx == lk_idx)) begin
            lk_state = upd_nxt;
        end
    end

    // NOTE: the counter array is plain flops and is cleared by reset like any
    // other state; predictions right after reset depend on it reading 00.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= BP_STRONG_NT;
        end else if (desactivar_bp_i) begin
            for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= BP_STRONG_NT;
        end else if (upd_valid_i) begin
            // NOTE: non-blocking assignments for all sequential state, so the
            // forwarding logic above always sees the pre-edge table.
            ctr_q[upd_idx] <= upd_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pred_valid_o <= 1'b0;
            pred_taken_o <= 1'b0;
            pred_state_o <= BP_STRONG_NT;
        end else begin
            pred_valid_o <= lookup_valid_i;
            // Without a request the last prediction is held.
            if (lookup_valid_i) begin
                pred_state_o <= lk_state;
                pred_taken_o <= lk_state[1];
            end
        end
    end

endmodule

// File: tb/tb_branch_history_table.sv
// Self-checking bench for branch_history_table (ENTRIES=64, PC_W=32, IDX_LSB=2).
// Directed vectors carry hand-derived expected states; the reset sequence and
// the random phase take expectations from a small behavioural model. Expected
// predictions go into a queue when the lookup is driven and are popped when
// the registered prediction appears one cycle later.
module tb_branch_history_table;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        desactivar_bp_i;
    logic        lookup_valid_i;
    logic [31:0] lookup_pc_i;
    logic        pred_valid_o;
    logic        pred_taken_o;
    logic [1:0]  pred_state_o;
    logic        upd_valid_i;
    logic [31:0] upd_pc_i;
    logic        upd_taken_i;

    branch_history_table #(.ENTRIES(64), .PC_W(32), .IDX_LSB(2)) dut (
        .clk_i           (clk_i),
        .rst_n_i         (rst_n_i),
        .desactivar_bp_i (desactivar_bp_i),
        .lookup_valid_i  (lookup_valid_i),
        .lookup_pc_i     (lookup_pc_i),
        .pred_valid_o    (pred_valid_o),
        .pred_taken_o    (pred_taken_o),
        .pred_state_o    (pred_state_o),
        .upd_valid_i     (upd_valid_i),
        .upd_pc_i        (upd_pc_i),
        .upd_taken_i     (upd_taken_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        lv;
        logic [31:0] lpc;
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic        dis;
        int          exp;   // expected state for a lookup row, -1 = use model
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    int   model [64];
    int   exp_q [$];
    int   last_state = 0;
    vec_t vecs [$];

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic int pc_idx(input logic [31:0] pc);
        return int'((pc >> 2) & 32'd63);
    endfunction

    function automatic int model_next(input int v, input logic taken);
        if (taken) return (v < 3) ? v + 1 : 3;
        return (v > 0) ? v - 1 : 0;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 64; i++) model[i] = 0;
    endtask

    // One cycle: drive at posedge+1, compare at the following posedge+1.
    task automatic step(input logic lv, input logic [31:0] lpc, input logic uv,
                        input logic [31:0] upc, input logic ut, input logic dis,
                        input int exp_state);
        int li;
        int ui;
        int m;
        int e;
        li = pc_idx(lpc);
        ui = pc_idx(upc);
        if (dis) m = 0;
        else if (uv && ui == li) m = model_next(model[ui], ut);
        else m = model[li];
        if (lv) exp_q.push_back((exp_state >= 0) ? exp_state : m);
        if (dis) model_clear();
        else if (uv) model[ui] = model_next(model[ui], ut);

        lookup_valid_i  = lv;
        lookup_pc_i     = lpc;
        upd_valid_i     = uv;
        upd_pc_i        = upc;
        upd_taken_i     = ut;
        desactivar_bp_i = dis;
        @(posedge clk_i);
        #1;
        check("pred_valid", int'(pred_valid_o), int'(lv));
        if (lv) begin
            if (exp_q.size() == 0) begin
                check("scoreboard_empty", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("pred_state", int'(pred_state_o), e);
                check("pred_taken", int'(pred_taken_o), (e >> 1) & 1);
                last_state = e;
            end
        end else begin
            check("pred_state_hold", int'(pred_state_o), last_state);
        end
    endtask

    task automatic idle_inputs();
        lookup_valid_i  = 1'b0;
        lookup_pc_i     = '0;
        upd_valid_i     = 1'b0;
        upd_pc_i        = '0;
        upd_taken_i     = 1'b0;
        desactivar_bp_i = 1'b0;
    endtask

    function automatic vec_t lk(input logic [31:0] pc, input int e);
        return '{lv: 1'b1, lpc: pc, uv: 1'b0, upc: 32'h0, ut: 1'b0, dis: 1'b0, exp: e};
    endfunction

    function automatic vec_t up(input logic [31:0] pc, input logic t);
        return '{lv: 1'b0, lpc: 32'h0, uv: 1'b1, upc: pc, ut: t, dis: 1'b0, exp: -1};
    endfunction

    initial begin
        logic [31:0] lpc;
        logic [31:0] upc;

        // Directed vectors, one cycle each, expectations derived by hand.
        vecs.push_back(lk(32'h100, 0));                    // 1: fresh table
        vecs.push_back(up(32'h40, 1'b1));                  // 2: 00 -> 01
        vecs.push_back(up(32'h40, 1'b1));                  //    01 -> 10
        vecs.push_back(lk(32'h40, 2));
        vecs.push_back(up(32'h40, 1'b1));                  //    10 -> 11
        vecs.push_back(up(32'h40, 1'b1));                  //    saturates at 11
        vecs.push_back(lk(32'h40, 3));
        for (int i = 0; i < 5; i++) vecs.push_back(up(32'h40, 1'b0));
        vecs.push_back(lk(32'h40, 0));                     //    saturates at 00
        vecs.push_back(up(32'h40, 1'b1));                  // 3: 0x40 -> 01
        vecs.push_back(lk(32'h140, 1));                    //    alias of 0x40
        vecs.push_back(lk(32'h44, 0));                     //    neighbour untouched
        vecs.push_back(up(32'h80, 1'b1));                  // 4: 0x80 -> 01
        vecs.push_back('{lv: 1'b1, lpc: 32'h80, uv: 1'b1, upc: 32'h80, ut: 1'b1, dis: 1'b0, exp: 2});
        vecs.push_back(up(32'h80, 1'b1));                  // 5: 0x80 -> 11
        vecs.push_back(lk(32'h80, 3));
        vecs.push_back('{lv: 1'b1, lpc: 32'h80, uv: 1'b1, upc: 32'h80, ut: 1'b1, dis: 1'b1, exp: 0});
        vecs.push_back(lk(32'h80, 0));
        vecs.push_back(lk(32'h40, 0));                     //    whole table cleared

        model_clear();
        idle_inputs();
        rst_n_i = 1'b0;
        #2;
        check("reset_pred_valid", int'(pred_valid_o), 0);
        check("reset_pred_state", int'(pred_state_o), 0);
        check("reset_pred_taken", int'(pred_taken_o), 0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(posedge clk_i);
        #1;

        foreach (vecs[i])
            step(vecs[i].lv, vecs[i].lpc, vecs[i].uv, vecs[i].upc, vecs[i].ut,
                 vecs[i].dis, vecs[i].exp);

        // 6: asynchronous reset in the middle of an update stream.
        step(1'b0, 32'h0, 1'b1, 32'h80, 1'b1, 1'b0, -1);
        step(1'b0, 32'h0, 1'b1, 32'h80, 1'b1, 1'b0, -1);
        step(1'b0, 32'h0, 1'b1, 32'h40, 1'b1, 1'b0, -1);
        step(1'b1, 32'h80, 1'b1, 32'h80, 1'b1, 1'b0, 3);
        lookup_valid_i = 1'b1;
        lookup_pc_i    = 32'h80;
        upd_valid_i    = 1'b1;
        upd_pc_i       = 32'h40;
        upd_taken_i    = 1'b1;
        #2;
        rst_n_i = 1'b0;
        #1;
        check("midreset_pred_valid", int'(pred_valid_o), 0);
        check("midreset_pred_state", int'(pred_state_o), 0);
        check("midreset_pred_taken", int'(pred_taken_o), 0);
        idle_inputs();
        model_clear();
        exp_q.delete();
        last_state = 0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(posedge clk_i);
        #1;
        step(1'b1, 32'h80, 1'b0, 32'h0, 1'b0, 1'b0, 0);
        step(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0, 0);
        step(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 0);

        // Random traffic over a few aliasing indices, checked against the model.
        for (int n = 0; n < 300; n++) begin
            lpc = (32'($urandom_range(0, 7)) << 2) | (32'($urandom_range(0, 1)) << 8);
            upc = (32'($urandom_range(0, 7)) << 2) | (32'($urandom_range(0, 1)) << 8);
            step(1'($urandom_range(0, 1)), lpc, 1'($urandom_range(0, 3) != 0), upc,
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 31) == 0), -1);
        end

        idle_inputs();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
